// File: rtl/posit_decode_if.sv
// Handshake and result bundle between a posit word producer and posit_decode.
// The master side supplies words and consumes results; the slave side is the decoder.
interface posit_decode_if #(
    parameter int N  = 32,
    parameter int ES = 3
);
    localparam int EW = (ES > 0) ? ES : 1;

    logic [N-1:0]       posit_in;
    logic               in_valid;
    logic               in_ready;
    logic               sign_out;
    logic signed [7:0]  k_out;
    logic [EW-1:0]      exp_out;
    logic [31:0]        frac_out;
    logic [5:0]         frac_len;
    logic               is_zero;
    logic               is_nar;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output posit_in, in_valid, out_ready,
        input  in_ready, sign_out, k_out, exp_out, frac_out, frac_len,
               is_zero, is_nar, out_valid
    );

    modport slave (
        input  posit_in, in_valid, out_ready,
        output in_ready, sign_out, k_out, exp_out, frac_out, frac_len,
               is_zero, is_nar, out_valid
    );
endinterface

// File: rtl/posit_decode.sv
// Sequential posit field decoder: resolves sign/magnitude, serially measures the
// regime run, then unpacks exponent and an MSB-aligned fraction for the datapath.
module posit_decode #(
    parameter int N  = 32,
    parameter int ES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    posit_decode_if.slave  bus
);
    localparam int EW = (ES > 0) ? ES : 1;
    localparam int IW = $clog2(N);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CONV = 3'd1;
    localparam logic [2:0] SCAN = 3'd2;
    localparam logic [2:0] PACK = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [N-1:0] NAR_WORD = {1'b1, {(N-1){1'b0}}};

    logic [2:0]        state_r;
    logic [N-1:0]      posit_r;
    logic [N-1:0]      mag_r;
    logic              run_bit_r;
    logic [5:0]        m_r;
    logic [IW-1:0]     idx_r;
    logic              special_r;

    logic              sign_r;
    logic signed [7:0] k_r;
    logic [EW-1:0]     exp_r;
    logic [31:0]       frac_r;
    logic [5:0]        frac_len_r;
    logic              is_zero_r;
    logic              is_nar_r;
    logic              out_valid_r;
    logic              in_ready_r;

    logic [N-1:0]      conv_mag_s;
    logic              scan_bit_s;
    logic [5:0]        reg_len_s;
    logic [5:0]        rem_s;
    logic [31:0]       body_s;
    logic [EW-1:0]     exp_s;
    logic [31:0]       frac_s;
    logic [5:0]        frac_len_s;
    logic signed [7:0] k_s;

    // Magnitude, current scan bit and the PACK-stage field extraction.
    always_comb begin
        conv_mag_s = posit_r;
        if (posit_r[N-1]) begin
            conv_mag_s = ~posit_r + N'(1);
        end else begin
            conv_mag_s = posit_r;
        end

        scan_bit_s = mag_r[idx_r];

        // A run that fills every bit below the sign has no terminator bit.
        if (m_r < 6'(N-1)) begin
            reg_len_s = m_r + 6'd1;
        end else begin
            reg_len_s = 6'(N-1);
        end
        rem_s = 6'(N-1) - reg_len_s;

        // Drop sign and regime so exponent then fraction sit at bit 31.
        body_s = (32'(mag_r) << (32 - N)) << (reg_len_s + 6'd1);
        exp_s  = EW'(body_s >> (32 - ES));
        frac_s = body_s << ES;

        if (rem_s > 6'(ES)) begin
            frac_len_s = rem_s - 6'(ES);
        end else begin
            frac_len_s = 6'd0;
        end

        if (run_bit_r) begin
            k_s = $signed({2'b00, m_r}) - 8'sd1;
        end else begin
            k_s = 8'sd0 - $signed({2'b00, m_r});
        end
    end

    // Control FSM and all result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            posit_r     <= '0;
            mag_r       <= '0;
            run_bit_r   <= 1'b0;
            m_r         <= 6'd0;
            idx_r       <= '0;
            special_r   <= 1'b0;
            sign_r      <= 1'b0;
            k_r         <= 8'sd0;
            exp_r       <= '0;
            frac_r      <= 32'd0;
            frac_len_r  <= 6'd0;
            is_zero_r   <= 1'b0;
            is_nar_r    <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        posit_r    <= bus.posit_in;
                        sign_r     <= 1'b0;
                        k_r        <= 8'sd0;
                        exp_r      <= '0;
                        frac_r     <= 32'd0;
                        frac_len_r <= 6'd0;
                        is_zero_r  <= 1'b0;
                        is_nar_r   <= 1'b0;
                        in_ready_r <= 1'b0;
                        state_r    <= CONV;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                CONV: begin
                    mag_r <= conv_mag_s;
                    if (posit_r == '0) begin
                        special_r <= 1'b1;
                        is_zero_r <= 1'b1;
                        sign_r    <= posit_r[N-1];
                        state_r   <= PACK;
                    end else if (posit_r == NAR_WORD) begin
                        special_r <= 1'b1;
                        is_nar_r  <= 1'b1;
                        sign_r    <= posit_r[N-1];
                        state_r   <= PACK;
                    end else begin
                        special_r <= 1'b0;
                        run_bit_r <= conv_mag_s[N-2];
                        m_r       <= 6'd0;
                        idx_r     <= IW'(N-2);
                        state_r   <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_bit_s == run_bit_r) begin
                        m_r <= m_r + 6'd1;
                        if (idx_r == '0) begin
                            state_r <= PACK;
                        end else begin
                            idx_r <= idx_r - IW'(1);
                        end
                    end else begin
                        state_r <= PACK;
                    end
                end
                PACK: begin
                    if (!special_r) begin
                        sign_r     <= posit_r[N-1];
                        k_r        <= k_s;
                        exp_r      <= exp_s;
                        frac_r     <= frac_s;
                        frac_len_r <= frac_len_s;
                    end
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.sign_out  = sign_r;
    assign bus.k_out     = k_r;
    assign bus.exp_out   = exp_r;
    assign bus.frac_out  = frac_r;
    assign bus.frac_len  = frac_len_r;
    assign bus.is_zero   = is_zero_r;
    assign bus.is_nar    = is_nar_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_posit_decode.sv
// Self-checking bench for posit_decode (N=32, ES=3) using an expected-result queue.
module tb_posit_decode;
    typedef struct packed {
        logic        sign;
        logic [7:0]  k;
        logic [2:0]  ex;
        logic [31:0] frac;
        logic [5:0]  flen;
        logic        zero;
        logic        nar;
        logic [7:0]  lat;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    res_t sbq[$];

    posit_decode_if #(.N(32), .ES(3)) bus ();

    posit_decode #(.N(32), .ES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t mk(input logic sign, input logic [7:0] k, input logic [2:0] ex,
                                input logic [31:0] frac, input logic [5:0] flen,
                                input logic zero, input logic nar, input logic [7:0] lat);
        res_t r;
        r.sign = sign; r.k = k; r.ex = ex; r.frac = frac; r.flen = flen;
        r.zero = zero; r.nar = nar; r.lat = lat;
        return r;
    endfunction

    // Reference decoder walking the word bit by bit.
    function automatic res_t model(input logic [31:0] w);
        res_t        r;
        logic [31:0] mag;
        logic        rb;
        int          i, m, nxt, pos;
        r = '0;
        r.sign = w[31];
        if (w == 32'h0000_0000) begin
            r.zero = 1'b1; r.lat = 8'd2; return r;
        end
        if (w == 32'h8000_0000) begin
            r.nar = 1'b1; r.lat = 8'd2; return r;
        end
        mag = w[31] ? (32'h0000_0000 - w) : w;
        rb  = mag[30];
        m   = 0;
        i   = 30;
        while (i >= 0) begin
            if (mag[i] != rb) break;
            m++;
            i--;
        end
        r.k = rb ? 8'(m - 1) : 8'(-m);
        nxt = (i >= 0) ? i - 1 : -1;
        for (int j = 0; j < 3; j++) begin
            pos  = nxt - j;
            r.ex = {r.ex[1:0], (pos >= 0) ? mag[pos] : 1'b0};
        end
        pos = nxt - 3;
        if (pos >= 0) begin
            r.flen = 6'(pos + 1);
            for (int j = 0; j <= pos; j++) r.frac[31 - pos + j] = mag[j];
        end
        r.lat = 8'((((m + 1) < 31) ? (m + 1) : 31) + 2);
        return r;
    endfunction

    function automatic res_t sample(input logic [7:0] lat);
        res_t r;
        r.sign = bus.sign_out; r.k = bus.k_out; r.ex = bus.exp_out; r.frac = bus.frac_out;
        r.flen = bus.frac_len; r.zero = bus.is_zero; r.nar = bus.is_nar; r.lat = lat;
        return r;
    endfunction

    // Offer a word, then count edges from the accepting edge until out_valid appears.
    task automatic run_word(input logic [31:0] w, output res_t got);
        int lat;
        int guard;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        bus.posit_in = w;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        got = sample(8'(lat));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        res_t got;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        got = sample(8'd0);
        n_cmp++;
        if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset: outputs=%h out_valid=%b in_ready=%b, required all 0 / 0 / 1",
                     got, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_normal();
        logic [31:0] words [3];
        res_t got, e;
        words = '{32'h4000_0000, 32'h4A00_0000, 32'hC000_0000};
        sbq.push_back(mk(1'b0, 8'd0, 3'd0, 32'h0000_0000, 6'd26, 1'b0, 1'b0, 8'd4));
        sbq.push_back(mk(1'b0, 8'd0, 3'd2, 32'h8000_0000, 6'd26, 1'b0, 1'b0, 8'd4));
        sbq.push_back(mk(1'b1, 8'd0, 3'd0, 32'h0000_0000, 6'd26, 1'b0, 1'b0, 8'd4));
        foreach (words[i]) begin
            run_word(words[i], got);
            e = sbq.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL normal %h: got %h required %h", words[i], got, e);
            end
            consume();
        end
    endtask

    task automatic test_extremes();
        logic [31:0] words [2];
        res_t got, e;
        words = '{32'h7FFF_FFFF, 32'h0000_0001};
        sbq.push_back(mk(1'b0, 8'd30, 3'd0, 32'h0, 6'd0, 1'b0, 1'b0, 8'd33));
        sbq.push_back(mk(1'b0, 8'hE2, 3'd0, 32'h0, 6'd0, 1'b0, 1'b0, 8'd33));
        foreach (words[i]) begin
            run_word(words[i], got);
            e = sbq.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL extreme %h: got %h required %h", words[i], got, e);
            end
            consume();
        end
    endtask

    task automatic test_specials();
        logic [31:0] words [2];
        res_t got, e;
        words = '{32'h0000_0000, 32'h8000_0000};
        sbq.push_back(mk(1'b0, 8'd0, 3'd0, 32'h0, 6'd0, 1'b1, 1'b0, 8'd2));
        sbq.push_back(mk(1'b1, 8'd0, 3'd0, 32'h0, 6'd0, 1'b0, 1'b1, 8'd2));
        foreach (words[i]) begin
            run_word(words[i], got);
            e = sbq.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL special %h: got %h required %h", words[i], got, e);
            end
            consume();
        end
    endtask

    task automatic test_mixed();
        logic [31:0] w;
        res_t got, e;
        for (int i = 0; i < 20; i++) begin
            case (i)
                0: w = 32'hFFFF_FFFF;
                1: w = 32'h8000_0001;
                2: w = 32'h3FFF_FFFF;
                3: w = 32'h4000_0001;
                4: w = 32'h0123_4567;
                5: w = 32'h7FFF_FFFE;
                default: w = $urandom;
            endcase
            sbq.push_back(model(w));
            run_word(w, got);
            e = sbq.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mixed %h: got %h required %h", w, got, e);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        res_t snap, cur, e;
        int   lat;
        bus.posit_in = 32'h7FFF_FFFF;
        bus.in_valid = 1'b1;
        sbq.push_back(mk(1'b0, 8'd30, 3'd0, 32'h0, 6'd0, 1'b0, 1'b0, 8'd33));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
            if (lat == 3) begin
                bus.posit_in = 32'h0000_0000;
                bus.in_valid = 1'b1;
            end
            if (lat == 5) begin
                bus.in_valid = 1'b0;
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL scan_in_ready: got %b required 0", bus.in_ready);
                end
            end
        end
        snap = sample(8'(lat));
        e = sbq.pop_front();
        n_cmp++;
        if (snap !== e) begin
            n_err++;
            $display("FAIL ignore_in_valid: got %h required %h", snap, e);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            cur = sample(snap.lat);
            n_cmp++;
            if (cur !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL hold cycle %0d: got %h ov=%b ir=%b required %h ov=1 ir=0",
                         c, cur, bus.out_valid, bus.in_ready, snap);
            end
        end
        consume();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL release: ov=%b ir=%b required ov=0 ir=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        res_t got, e;
        words = '{32'hFFFF_FFFF, 32'h4A00_0000, 32'h0000_0000};
        bus.out_ready = 1'b1;
        foreach (words[i]) begin
            sbq.push_back(model(words[i]));
            run_word(words[i], got);
            e = sbq.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL b2b %h: got %h required %h", words[i], got, e);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_idle %0d: ov=%b ir=%b required ov=0 ir=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        res_t got, e;
        logic seen;
        bus.posit_in = 32'h7FFF_FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        got = sample(8'd0);
        n_cmp++;
        if (got !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: outputs=%h ov=%b ir=%b required all 0 / 0 / 1",
                     got, bus.out_valid, bus.in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_result: out_valid seen=%b required 0", seen);
        end
        sbq.push_back(mk(1'b0, 8'd0, 3'd2, 32'h8000_0000, 6'd26, 1'b0, 1'b0, 8'd4));
        run_word(32'h4A00_0000, got);
        e = sbq.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL after_reset: got %h required %h", got, e);
        end
        consume();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.posit_in  = 32'h0000_0000;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_normal();
        test_extremes();
        test_specials();
        test_mixed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not end within time limit");
        $fatal(1);
    end
endmodule
